// File: rtl/issue_ctrl_pkg.sv
// rtl/issue_ctrl_pkg.sv - shared register-file constants and one-hot helper for issue_ctrl
package issue_ctrl_pkg;
  localparam int REG_NUM         = 32;
  localparam int REG_IDX_W       = 5;
  localparam int MAX_OUTST_BOUND = 7;
  localparam int CNT_W           = 3;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [REG_NUM-1:0]   reg_mask_t;

  function automatic reg_mask_t onehot(input reg_idx_t idx);
    reg_mask_t m;
    m      = '0;
    m[idx] = 1'b1;
    return m;
  endfunction
endpackage

// File: rtl/issue_ctrl_if.sv
// rtl/issue_ctrl_if.sv - decode/issue/write-back signal bundle for issue_ctrl
interface issue_ctrl_if #(parameter int PL_W = 64);
  import issue_ctrl_pkg::*;

  logic                 dec_valid;
  logic                 dec_ready;
  logic                 rs1_en, rs2_en, rd_en;
  logic [REG_IDX_W-1:0] rs1_idx, rs2_idx, rd_idx;
  logic                 load;
  logic                 speci;
  logic [PL_W-1:0]      dec_pl;
  logic                 iss_valid;
  logic                 iss_ready;
  logic [PL_W-1:0]      iss_pl;
  logic                 wb_valid;
  logic [REG_IDX_W-1:0] wb_idx;
  logic                 flush;
  logic                 busy;

  modport master (
    output dec_valid, rs1_en, rs2_en, rd_en, rs1_idx, rs2_idx, rd_idx,
           load, speci, dec_pl, iss_ready, wb_valid, wb_idx, flush,
    input  dec_ready, iss_valid, iss_pl, busy
  );

  modport slave (
    input  dec_valid, rs1_en, rs2_en, rd_en, rs1_idx, rs2_idx, rd_idx,
           load, speci, dec_pl, iss_ready, wb_valid, wb_idx, flush,
    output dec_ready, iss_valid, iss_pl, busy
  );
endinterface

// File: rtl/issue_scoreboard.sv
// rtl/issue_scoreboard.sv - pending-load register scoreboard and outstanding-load counter
// ISSUE_BYPASS_EN: hazard lookups see same-cycle write-backs already applied.
module issue_scoreboard
  import issue_ctrl_pkg::*;
#(
  parameter int LIMIT = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     acc_load,
  input  logic     acc_set,
  input  reg_idx_t acc_idx,
  input  logic     wb_valid,
  input  reg_idx_t wb_idx,
  input  logic     rel_load,
  input  logic     rel_set,
  input  reg_idx_t rel_idx,
  input  reg_idx_t rs1_idx,
  input  reg_idx_t rs2_idx,
  input  reg_idx_t rd_idx,
  output logic     rs1_pend,
  output logic     rs2_pend,
  output logic     rd_pend,
  output logic     cnt_full,
  output logic     cnt_nz
);
  reg_mask_t        sb, sb_d, sb_chk;
  logic [CNT_W-1:0] cnt, cnt_d, cnt_chk;
  logic [CNT_W+1:0] up, dn;

  // Clears go first so that a same-index set from an accept wins.
  always_comb begin
    sb_d = sb;
    if (wb_valid) sb_d = sb_d & ~onehot(wb_idx);
    if (rel_set)  sb_d = sb_d & ~onehot(rel_idx);
    if (acc_set)  sb_d = sb_d | onehot(acc_idx);
    sb_d[0] = 1'b0;
    up    = (CNT_W+2)'(cnt) + (CNT_W+2)'(acc_load);
    dn    = (CNT_W+2)'(wb_valid) + (CNT_W+2)'(rel_load);
    cnt_d = (up > dn) ? CNT_W'(up - dn) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb  <= '0;
      cnt <= '0;
    end else begin
      sb  <= sb_d;
      cnt <= cnt_d;
    end
  end

`ifdef ISSUE_BYPASS_EN
  assign sb_chk  = sb & ~({REG_NUM{wb_valid}} & onehot(wb_idx));
  assign cnt_chk = (wb_valid && cnt != '0) ? cnt - CNT_W'(1) : cnt;
`else
  assign sb_chk  = sb;
  assign cnt_chk = cnt;
`endif

  assign rs1_pend = sb_chk[rs1_idx];
  assign rs2_pend = sb_chk[rs2_idx];
  assign rd_pend  = sb_chk[rd_idx];
  assign cnt_full = (cnt_chk == CNT_W'(LIMIT));
  assign cnt_nz   = (cnt != '0);
endmodule

// File: rtl/issue_ctrl.sv
// rtl/issue_ctrl.sv - decode-to-execute issue register with load scoreboard stall logic
// ISSUE_BYPASS_EN (optional): write-backs release stalled instructions in the same cycle.
module issue_ctrl
  import issue_ctrl_pkg::*;
#(
  parameter int PL_W      = 64,
  parameter int MAX_OUTST = 2
) (
  input logic         clk,
  input logic         rst_n,
  issue_ctrl_if.slave bus
);
  localparam int LIMIT = (MAX_OUTST > MAX_OUTST_BOUND) ? MAX_OUTST_BOUND :
                         (MAX_OUTST < 1) ? 1 : MAX_OUTST;

  logic            iss_valid_q;
  logic [PL_W-1:0] iss_pl_q;
  logic            hold_load;
  reg_idx_t        hold_rd;
  logic            rs1_pend, rs2_pend, rd_pend, cnt_full, cnt_nz;
  logic            hazard, ready, accept, busy;
  logic            acc_load, acc_set, rel_load, rel_set;

  assign busy = cnt_nz | iss_valid_q;

  assign hazard = (bus.rs1_en & (bus.rs1_idx != '0) & rs1_pend)
                | (bus.rs2_en & (bus.rs2_idx != '0) & rs2_pend)
                | (bus.rd_en  & (bus.rd_idx  != '0) & rd_pend)
                | (bus.load & cnt_full)
                | (bus.speci & busy);

  assign ready  = ~bus.flush & ~hazard & (~iss_valid_q | bus.iss_ready);
  assign accept = bus.dec_valid & ready;

  assign acc_load = accept & bus.load;
  assign acc_set  = acc_load & bus.rd_en & (bus.rd_idx != '0);
  // A flushed load never reaches the load unit, so its reservation is returned here.
  assign rel_load = bus.flush & iss_valid_q & hold_load;
  assign rel_set  = rel_load & (hold_rd != '0);

  issue_scoreboard #(.LIMIT(LIMIT)) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .acc_load (acc_load),
    .acc_set  (acc_set),
    .acc_idx  (bus.rd_idx),
    .wb_valid (bus.wb_valid),
    .wb_idx   (bus.wb_idx),
    .rel_load (rel_load),
    .rel_set  (rel_set),
    .rel_idx  (hold_rd),
    .rs1_idx  (bus.rs1_idx),
    .rs2_idx  (bus.rs2_idx),
    .rd_idx   (bus.rd_idx),
    .rs1_pend (rs1_pend),
    .rs2_pend (rs2_pend),
    .rd_pend  (rd_pend),
    .cnt_full (cnt_full),
    .cnt_nz   (cnt_nz)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_valid_q <= 1'b0;
      iss_pl_q    <= '0;
      hold_load   <= 1'b0;
      hold_rd     <= '0;
    end else if (bus.flush) begin
      iss_valid_q <= 1'b0;
      hold_load   <= 1'b0;
      hold_rd     <= '0;
    end else if (accept) begin
      iss_valid_q <= 1'b1;
      iss_pl_q    <= bus.dec_pl;
      hold_load   <= bus.load;
      hold_rd     <= bus.rd_en ? bus.rd_idx : '0;
    end else if (bus.iss_ready) begin
      iss_valid_q <= 1'b0;
      hold_load   <= 1'b0;
    end
  end

  assign bus.dec_ready = ready;
  assign bus.iss_valid = iss_valid_q;
  assign bus.iss_pl    = iss_pl_q;
  assign bus.busy      = busy;
endmodule
